bmf_block_pack: RTL and testbench

Streaming encoder that converts scalar bfloat16 values into a block-minifloat word: a shared exponent-bias field followed by LENGTH minifloats. It accepts one scalar per handshake and buffers a full block while tracking the maximum exponent. It then derives the shared bias, re-encodes each element relative to that bias, and presents the block on a valid/ready output. It is the producer for the block-level add/sub datapath, which consumes words in exactly this format.

---
 rtl/bmf_block_pack.sv | 105 ++++++++++
 tb/tb_bmf_block_pack.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmf_block_pack.sv
// bmf_block_pack: packs a stream of bfloat16 scalars into one block-minifloat word.
// Revision 1.0
`default_nettype none

module bmf_block_pack #(
  parameter int LENGTH   = 4,
  parameter int NEXP     = 4,
  parameter int NSIG     = 3,
  parameter int EXP_BIAS = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [15:0]                      in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXP_BIAS+LENGTH*(1+NEXP+NSIG)-1:0] out_block
);

  localparam int C_SIZE = 1 + NEXP + NSIG;
  localparam int C_CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [EXP_BIAS-1:0] C_EMAX = EXP_BIAS'((1 << NEXP) - 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]                        r_state;
  logic [C_CW-1:0]                   r_cnt;
  logic [7:0]                        r_max;
  logic [15:0]                       r_slot [LENGTH];
  logic [EXP_BIAS+LENGTH*C_SIZE-1:0] r_out;

  logic                      w_beat;
  logic                      w_close;
  logic [EXP_BIAS-1:0]       w_max_ext;
  logic [EXP_BIAS-1:0]       w_bias;
  logic [LENGTH*C_SIZE-1:0]  w_elems;

  assign w_beat    = in_valid && (r_state == S_FILL);
  assign w_close   = w_beat && (in_last || (r_cnt == C_CW'(LENGTH - 1)));
  assign w_max_ext = EXP_BIAS'(r_max);
  assign w_bias    = (w_max_ext >= C_EMAX) ? (w_max_ext - C_EMAX) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_elem
      logic [7:0]                w_exp;
      logic signed [EXP_BIAS:0]  w_loc;
      logic                      w_flush;
      logic                      w_unused;

      assign w_exp   = r_slot[gi][14:7];
      assign w_loc   = $signed({1'b0, EXP_BIAS'(w_exp)}) - $signed({1'b0, w_bias});
      // Zero inputs and anything below the smallest normal collapse to signed zero.
      assign w_flush = (w_exp == 8'd0) || (w_loc < $signed((EXP_BIAS+1)'(1)));
      assign w_elems[gi*C_SIZE +: C_SIZE] = w_flush
          ? {r_slot[gi][15], (C_SIZE-1)'(0)}
          : {r_slot[gi][15], w_loc[NEXP-1:0], r_slot[gi][6 -: NSIG]};
      assign w_unused = ^{r_slot[gi][6-NSIG:0], w_loc[EXP_BIAS:NEXP]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_max   <= '0;
      r_out   <= '0;
      for (int i = 0; i < LENGTH; i++) r_slot[i] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_beat) begin
            r_slot[r_cnt] <= in_data;
            r_cnt         <= r_cnt + C_CW'(1);
            if (in_data[14:7] > r_max) r_max <= in_data[14:7];
            if (w_close) r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_out   <= {w_bias, w_elems};
          r_cnt   <= '0;
          r_max   <= '0;
          // Cleared so a short block reads zeros in its unwritten slots.
          for (int i = 0; i < LENGTH; i++) r_slot[i] <= '0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_HOLD);
  assign out_block = r_out;

endmodule

`default_nettype wire

// File: tb/tb_bmf_block_pack.sv
// Directed testbench for bmf_block_pack (LENGTH=4, NEXP=4, NSIG=3, EXP_BIAS=8).
`default_nettype none

module tb_bmf_block_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_block;

  int checks = 0;
  int errors = 0;

  bmf_block_pack #(.LENGTH(4), .NEXP(4), .NSIG(3), .EXP_BIAS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  always #5 clk = ~clk;

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [15:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin errors++; $display("FAIL send_beat timeout in_ready=%b", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    ok = (out_valid === 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_block !== 40'h0) begin errors++; $display("FAIL reset_out_block got %h want 0", out_block); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b0);
    send_beat(16'hBFC0, 1'b0);
    send_beat(16'h3F00, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_conv_cycle got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency got valid=%b want 1", out_valid); end
    checks++;
    if (out_block !== 40'h7168F47870) begin errors++; $display("FAIL full_block got %h want 7168f47870", out_block); end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_hs got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    send_beat(16'h4000, 1'b0);
    send_beat(16'h3780, 1'b0);
    send_beat(16'h0000, 1'b0);
    send_beat(16'h8000, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || out_block !== 40'h7180000078) begin
      errors++; $display("FAIL underflow_block got %h valid=%b want 7180000078", out_block, out_valid);
    end
    handshake();
  endtask

  task automatic test_small_max();
    bit ok;
    for (int i = 0; i < 4; i++) send_beat(16'h057F, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || out_block !== 40'h0057575757) begin
      errors++; $display("FAIL small_max_block got %h valid=%b want 0057575757", out_block, out_valid);
    end
    handshake();
  endtask

  task automatic test_early_close();
    bit ok;
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_block !== 40'h7100007870) begin
      errors++; $display("FAIL early_block got %h valid=%b want 7100007870", out_block, out_valid);
    end
    handshake();
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b0);
    send_beat(16'hBFC0, 1'b0);
    send_beat(16'h3F00, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || out_block !== 40'h7168F47870) begin
      errors++; $display("FAIL early_next_block got %h want 7168f47870", out_block);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable = 1'b1;
    bit blocked = 1'b1;
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b0);
    send_beat(16'hBFC0, 1'b0);
    send_beat(16'h3F00, 1'b0);
    in_valid = 1'b1; in_data = 16'h3F80;
    wait_valid(ok);
    for (int i = 0; i < 5; i++) begin
      if (out_block !== 40'h7168F47870 || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) blocked = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || !stable) begin errors++; $display("FAIL bp_stable got %h valid=%b want 7168f47870", out_block, out_valid); end
    checks++;
    if (!blocked) begin errors++; $display("FAIL bp_in_ready got nonzero during hold want 0"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_hs got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_beat(16'h4000, 1'b0);
    send_beat(16'hBFC0, 1'b0);
    send_beat(16'h3F00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_block !== 40'h7168F47870) begin
      errors++; $display("FAIL bp_next_block got %h valid=%b want 7168f47870", out_block, out_valid);
    end
    handshake();
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int i = 0; i < 4; i++) send_beat(16'h4000, 1'b0);
    wait_valid(ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got ok=%b valid=%b want 1/0", ok, out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h7F00, 1'b0);
    send_beat(16'h7F00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_block got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b0);
    send_beat(16'hBFC0, 1'b0);
    send_beat(16'h3F00, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || out_block !== 40'h7168F47870) begin
      errors++; $display("FAIL rst_next_block got %h want 7168f47870", out_block);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_full();
    test_underflow();
    test_small_max();
    test_early_close();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached without summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
